// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Arbiter and sequencer for the single-port data memory in the MEM stage.
// Two requesters share the port:
//   P - pipeline MEM stage (fixed priority)
//   D - debug unit (memory dump / preload over UART), protected against
//       starvation by a denial counter that forces a D grant once it
//       reaches MAX_WAIT.
// One transaction is in flight at a time. Writes complete in the grant
// cycle. Reads occupy the port for RD_LAT wait cycles and one response
// cycle.
//
// Ports:
//   clk, reset             clock (rising edge), async active-low reset
//   p_req/p_we/p_addr/p_wdata   pipeline request (held until served)
//   p_stall                pipeline freeze
//   p_rdata/p_rvalid       pipeline read data + one-cycle valid pulse
//   d_req/d_we/d_addr/d_wdata   debug request (held until served)
//   d_gnt                  debug request accepted this cycle
//   d_rdata/d_rvalid       debug read data + one-cycle valid pulse
//   mem_addr/mem_wdata/mem_we   to memory port A (mem_we bits all equal)
//   mem_rdata              from memory port A
//   busy                   a read is in progress (state != IDLE)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int B        = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         p_req,
  input  logic         p_we,
  input  logic [B-1:0] p_addr,
  input  logic [B-1:0] p_wdata,
  output logic         p_stall,
  output logic [B-1:0] p_rdata,
  output logic         p_rvalid,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [B-1:0] d_addr,
  input  logic [B-1:0] d_wdata,
  output logic         d_gnt,
  output logic [B-1:0] d_rdata,
  output logic         d_rvalid,
  output logic [B-1:0] mem_addr,
  output logic [B-1:0] mem_wdata,
  output logic [3:0]   mem_we,
  input  logic [B-1:0] mem_rdata,
  output logic         busy
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
  localparam logic [LW-1:0] LAT_LOAD   = LW'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          owner_q, owner_d;   // 1 = D owns the current read
  logic [B-1:0]  addr_q, addr_d;
  logic [B-1:0]  p_rdata_q, p_rdata_d;
  logic [B-1:0]  d_rdata_q, d_rdata_d;

  logic          p_win;
  logic          d_win;
  logic          in_resp;
  logic [B-1:0]  mem_addr_c;
  logic [B-1:0]  mem_wdata_c;
  logic [3:0]    mem_we_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      lat_q     <= '0;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      lat_q     <= lat_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      p_rdata_q <= p_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Arbitration is qualified with reset so that nothing is granted (and no
  // write strobe escapes) while the block is held in reset.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    lat_d       = lat_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    p_rdata_d   = p_rdata_q;
    d_rdata_d   = d_rdata_q;
    p_win       = 1'b0;
    d_win       = 1'b0;
    mem_addr_c  = addr_q;
    mem_wdata_c = '0;
    mem_we_c    = 4'b0000;

    case (state_q)
      IDLE: begin
        d_win = reset & d_req & (~p_req | (starve_q == STARVE_MAX));
        p_win = reset & p_req & ~d_win;

        if (p_win) begin
          mem_addr_c  = p_addr;
          mem_wdata_c = p_wdata;
          if (p_we) begin
            mem_we_c = 4'b1111;
          end else begin
            addr_d  = p_addr;
            owner_d = 1'b0;
            lat_d   = LAT_LOAD;
            state_d = RD_WAIT;
          end
        end else if (d_win) begin
          mem_addr_c  = d_addr;
          mem_wdata_c = d_wdata;
          if (d_we) begin
            mem_we_c = 4'b1111;
          end else begin
            addr_d  = d_addr;
            owner_d = 1'b1;
            lat_d   = LAT_LOAD;
            state_d = RD_WAIT;
          end
        end

        // Count only IDLE cycles in which D asked and lost.
        if (d_win) begin
          starve_d = '0;
        end else if (d_req && (starve_q != STARVE_MAX)) begin
          starve_d = starve_q + SW'(1);
        end
      end

      RD_WAIT: begin
        if (lat_q == '0) begin
          if (owner_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            p_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_resp  = (state_q == RESP);
  assign p_rvalid = in_resp & ~owner_q;
  assign d_rvalid = in_resp & owner_q;

  // A P read keeps the pipeline frozen until its response cycle; a P write
  // releases it in the grant cycle.
  assign p_stall  = p_req & ~(p_win & p_we) & ~p_rvalid;
  assign d_gnt    = d_win;

  assign mem_addr  = reset ? mem_addr_c  : '0;
  assign mem_wdata = reset ? mem_wdata_c : '0;
  assign mem_we    = mem_we_c;

  assign p_rdata = p_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter. A main instance (RD_LAT=1, MAX_WAIT=4) gets
// directed scenarios and a randomized run checked against a transaction-level
// reference model; a second instance (RD_LAT=3) checks longer read latency.
// Each instance is attached to a small word-addressed memory (index =
// addr[5:2]) whose read path is delayed by the instance's RD_LAT. While reset
// is low the memory is loaded with 0xC0DE0000 | index.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int B        = 32;
  localparam int MAX_WAIT = 4;
  localparam int RD_LAT   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         p_req, p_we, p_stall, p_rvalid;
  logic [B-1:0] p_addr, p_wdata, p_rdata;
  logic         d_req, d_we, d_gnt, d_rvalid;
  logic [B-1:0] d_addr, d_wdata, d_rdata;
  logic [B-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_we;
  logic         busy;

  logic         x_p_req, x_p_we, x_p_stall, x_p_rvalid;
  logic [B-1:0] x_p_addr, x_p_wdata, x_p_rdata;
  logic         x_d_req, x_d_we, x_d_gnt, x_d_rvalid;
  logic [B-1:0] x_d_addr, x_d_wdata, x_d_rdata;
  logic [B-1:0] x_mem_addr, x_mem_wdata, x_mem_rdata;
  logic [3:0]   x_mem_we;
  logic         x_busy;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.B(B), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.B(B), .RD_LAT(3), .MAX_WAIT(MAX_WAIT)) dut3 (
    .clk(clk), .reset(reset),
    .p_req(x_p_req), .p_we(x_p_we), .p_addr(x_p_addr), .p_wdata(x_p_wdata),
    .p_stall(x_p_stall), .p_rdata(x_p_rdata), .p_rvalid(x_p_rvalid),
    .d_req(x_d_req), .d_we(x_d_we), .d_addr(x_d_addr), .d_wdata(x_d_wdata),
    .d_gnt(x_d_gnt), .d_rdata(x_d_rdata), .d_rvalid(x_d_rvalid),
    .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata), .mem_we(x_mem_we),
    .mem_rdata(x_mem_rdata), .busy(x_busy)
  );

  // Memory models
  logic [31:0] ram [16];
  logic [31:0] pipe1;
  logic [31:0] xram [16];
  logic [31:0] xpipe [3];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (mem_we == 4'hF) begin
      ram[mem_addr[5:2]] <= mem_wdata;
    end
    pipe1 <= ram[mem_addr[5:2]];
  end
  assign mem_rdata = pipe1;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) xram[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (x_mem_we == 4'hF) begin
      xram[x_mem_addr[5:2]] <= x_mem_wdata;
    end
    xpipe[0] <= xram[x_mem_addr[5:2]];
    xpipe[1] <= xpipe[0];
    xpipe[2] <= xpipe[1];
  end
  assign x_mem_rdata = xpipe[2];

  // Transaction-level reference model for the main instance
  int          m_rem;      // cycles left in the current read (0 = port free)
  int          m_starve;   // consecutive lost IDLE cycles of D
  logic [31:0] m_addr;
  bit          m_own_d;
  bit          m_pw, m_dw;
  logic [31:0] ref_mem [16];
  logic [31:0] exp_p_rdata, exp_d_rdata;
  logic        e_busy, e_gnt, e_prv, e_drv, e_pstall, e_addr_valid;
  logic [3:0]  e_we;
  logic [31:0] e_addr, e_wdata;

  task automatic model_reset();
    m_rem = 0; m_starve = 0; m_addr = '0; m_own_d = 0;
    exp_p_rdata = '0; exp_d_rdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
  endtask

  task automatic model_eval();
    e_prv = 0; e_drv = 0;
    if (m_rem == 0) begin
      m_pw = p_req && !(d_req && m_starve == MAX_WAIT);
      m_dw = d_req && !m_pw;
      e_busy = 0;
      e_gnt  = m_dw;
      e_we   = ((m_pw && p_we) || (m_dw && d_we)) ? 4'hF : 4'h0;
      e_addr = m_pw ? p_addr : d_addr;
      e_wdata = m_pw ? p_wdata : d_wdata;
      e_addr_valid = m_pw || m_dw;
    end else begin
      m_pw = 0; m_dw = 0;
      e_busy = 1; e_gnt = 0; e_we = 4'h0;
      e_addr = m_addr; e_wdata = '0; e_addr_valid = 1;
      e_prv = (m_rem == 1) && !m_own_d;
      e_drv = (m_rem == 1) && m_own_d;
      if (e_prv) exp_p_rdata = ref_mem[m_addr[5:2]];
      if (e_drv) exp_d_rdata = ref_mem[m_addr[5:2]];
    end
    e_pstall = p_req && !(m_pw && p_we) && !e_prv;
  endtask

  task automatic model_advance();
    if (m_rem == 0) begin
      if (m_dw) m_starve = 0;
      else if (d_req && m_starve < MAX_WAIT) m_starve++;
      if (m_pw) begin
        if (p_we) ref_mem[p_addr[5:2]] = p_wdata;
        else begin m_rem = RD_LAT + 1; m_addr = p_addr; m_own_d = 0; end
      end else if (m_dw) begin
        if (d_we) ref_mem[d_addr[5:2]] = d_wdata;
        else begin m_rem = RD_LAT + 1; m_addr = d_addr; m_own_d = 1; end
      end
    end else begin
      m_rem--;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  task automatic drive_idle();
    p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    p_req = 1; p_we = 1; p_addr = 32'h3C; p_wdata = 32'h1111_2222;
    d_req = 1; d_we = 0; d_addr = 32'h24;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0h want 0", busy); end
    total++; if (mem_we !== 4'h0) begin bad++; $display("FAIL rst_mem_we: got %0h want 0", mem_we); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL rst_mem_addr: got %0h want 0", mem_addr); end
    total++; if (mem_wdata !== '0) begin bad++; $display("FAIL rst_mem_wdata: got %0h want 0", mem_wdata); end
    total++; if ({p_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid: got %0b want 00", {p_rvalid, d_rvalid}); end
    total++; if (p_rdata !== '0 || d_rdata !== '0) begin bad++; $display("FAIL rst_rdata: got %0h/%0h want 0/0", p_rdata, d_rdata); end
    drive_idle();
    @(posedge clk); #1;
    reset = 1;
  endtask

  task automatic test_p_write();
    p_req = 1; p_we = 1; p_addr = 32'h10; p_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (mem_we !== 4'hF) begin bad++; $display("FAIL pw_we: got %0h want f", mem_we); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL pw_addr: got %0h want 10", mem_addr); end
    total++; if (mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pw_wdata: got %0h want deadbeef", mem_wdata); end
    total++; if (p_stall !== 1'b0) begin bad++; $display("FAIL pw_stall: got %0h want 0", p_stall); end
    step();
    p_req = 0;
    @(negedge clk);
    total++; if (mem_we !== 4'h0) begin bad++; $display("FAIL pw_we_after: got %0h want 0", mem_we); end
    step();
  endtask

  task automatic test_p_read();
    p_req = 1; p_we = 0; p_addr = 32'h10;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (p_stall !== (c < 2 ? 1'b1 : 1'b0)) begin bad++; $display("FAIL pr_stall c%0d: got %0h want %0h", c, p_stall, c < 2); end
      total++; if (busy !== ((c == 1 || c == 2) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL pr_busy c%0d: got %0h", c, busy); end
      total++; if (p_rvalid !== (c == 2 ? 1'b1 : 1'b0)) begin bad++; $display("FAIL pr_rvalid c%0d: got %0h", c, p_rvalid); end
      if (c >= 2) begin
        total++; if (p_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pr_rdata c%0d: got %0h want deadbeef", c, p_rdata); end
      end
      if (c < 2) begin
        total++; if (mem_addr !== 32'h10 || mem_we !== 4'h0) begin bad++; $display("FAIL pr_mem c%0d: got %0h/%0h want 10/0", c, mem_addr, mem_we); end
      end
      step();
      if (c == 2) p_req = 0;
    end
  endtask

  task automatic test_contention();
    d_req = 1; d_we = 0; d_addr = 32'h20;
    p_req = 1; p_we = 1;
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin p_addr = 32'h40 + 32'(4 * c); p_wdata = 32'h5000_0000 + 32'(c); end
      @(negedge clk);
      if (c < 4 || c == 7) begin
        total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL ct_gnt c%0d: got %0h want 0", c, d_gnt); end
        total++; if (mem_we !== 4'hF || mem_addr !== p_addr || p_stall !== 1'b0) begin bad++; $display("FAIL ct_pwrite c%0d: got %0h/%0h/%0h want f/%0h/0", c, mem_we, mem_addr, p_stall, p_addr); end
      end else if (c == 4) begin
        total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL ct_gnt c4: got %0h want 1", d_gnt); end
        total++; if (mem_addr !== 32'h20 || mem_we !== 4'h0 || p_stall !== 1'b1) begin bad++; $display("FAIL ct_dgrant: got %0h/%0h/%0h want 20/0/1", mem_addr, mem_we, p_stall); end
      end else begin
        total++; if (busy !== 1'b1 || p_stall !== 1'b1) begin bad++; $display("FAIL ct_busy c%0d: got %0h/%0h want 1/1", c, busy, p_stall); end
        total++; if (d_rvalid !== (c == 6 ? 1'b1 : 1'b0) || p_rvalid !== 1'b0) begin bad++; $display("FAIL ct_rvalid c%0d: got %0h/%0h", c, d_rvalid, p_rvalid); end
        if (c == 6) begin
          total++; if (d_rdata !== 32'hC0DE_0008) begin bad++; $display("FAIL ct_drdata: got %0h want c0de0008", d_rdata); end
        end
      end
      step();
      if (c == 6) d_addr = 32'h24;
    end
    drive_idle();
  endtask

  task automatic test_back_to_back_queued();
    d_req = 1; d_we = 0; d_addr = 32'h24;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if (d_gnt !== (c == 0 ? 1'b1 : 1'b0)) begin bad++; $display("FAIL q_dgnt c%0d: got %0h", c, d_gnt); end
      total++; if (d_rvalid !== (c == 2 ? 1'b1 : 1'b0)) begin bad++; $display("FAIL q_drvalid c%0d: got %0h", c, d_rvalid); end
      total++; if (p_rvalid !== (c == 5 ? 1'b1 : 1'b0)) begin bad++; $display("FAIL q_prvalid c%0d: got %0h", c, p_rvalid); end
      if (c >= 1) begin
        total++; if (p_stall !== (c < 5 ? 1'b1 : 1'b0)) begin bad++; $display("FAIL q_pstall c%0d: got %0h", c, p_stall); end
      end
      if (c == 2) begin
        total++; if (d_rdata !== 32'hC0DE_0009) begin bad++; $display("FAIL q_drdata: got %0h want c0de0009", d_rdata); end
      end
      if (c == 3) begin
        total++; if (mem_addr !== 32'h28 || busy !== 1'b0) begin bad++; $display("FAIL q_pgrant: got %0h/%0h want 28/0", mem_addr, busy); end
      end
      if (c == 5) begin
        total++; if (p_rdata !== 32'hC0DE_000A) begin bad++; $display("FAIL q_prdata: got %0h want c0de000a", p_rdata); end
      end
      step();
      if (c == 0) begin p_req = 1; p_we = 0; p_addr = 32'h28; end
      if (c == 2) d_req = 0;
      if (c == 5) p_req = 0;
    end
  endtask

  task automatic test_reset_mid_read();
    p_req = 1; p_we = 0; p_addr = 32'h2C;
    @(posedge clk); #2;
    reset = 0;
    #1;
    total++; if (busy !== 1'b0 || mem_we !== 4'h0) begin bad++; $display("FAIL mr_async: got %0h/%0h want 0/0", busy, mem_we); end
    total++; if (p_rvalid !== 1'b0 || p_rdata !== '0) begin bad++; $display("FAIL mr_rdata: got %0h/%0h want 0/0", p_rvalid, p_rdata); end
    p_req = 0;
    step();
    reset = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (p_rvalid !== 1'b0 || d_rvalid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mr_quiet c%0d: got %0h/%0h/%0h want 0/0/0", c, p_rvalid, d_rvalid, busy); end
      step();
    end
    p_req = 1; p_we = 0; p_addr = 32'h2C;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (p_rvalid !== (c == 2 ? 1'b1 : 1'b0)) begin bad++; $display("FAIL mr_new_rvalid c%0d: got %0h", c, p_rvalid); end
      if (c == 2) begin
        total++; if (p_rdata !== 32'hC0DE_000B) begin bad++; $display("FAIL mr_new_rdata: got %0h want c0de000b", p_rdata); end
      end
      step();
    end
    p_req = 0;
  endtask

  task automatic test_lat3();
    x_p_req = 1; x_p_we = 0; x_p_addr = 32'h14;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if (x_p_rvalid !== (c == 4 ? 1'b1 : 1'b0)) begin bad++; $display("FAIL l3_rvalid c%0d: got %0h", c, x_p_rvalid); end
      total++; if (x_busy !== ((c >= 1 && c <= 4) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL l3_busy c%0d: got %0h", c, x_busy); end
      if (c <= 4) begin
        total++; if (x_mem_addr !== 32'h14 || x_mem_we !== 4'h0) begin bad++; $display("FAIL l3_addr c%0d: got %0h/%0h want 14/0", c, x_mem_addr, x_mem_we); end
        total++; if (x_p_stall !== (c < 4 ? 1'b1 : 1'b0)) begin bad++; $display("FAIL l3_stall c%0d: got %0h", c, x_p_stall); end
      end
      if (c == 4) begin
        total++; if (x_p_rdata !== 32'hC0DE_0005) begin bad++; $display("FAIL l3_rdata: got %0h want c0de0005", x_p_rdata); end
      end
      step();
      if (c == 4) x_p_req = 0;
    end
  endtask

  task automatic test_random();
    logic        n_preq, n_pwe, n_dreq, n_dwe;
    logic [31:0] n_paddr, n_pwdata, n_daddr, n_dwdata;
    drive_idle();
    reset = 0;
    step(); step();
    reset = 1;
    model_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      model_eval();
      total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy @%0d: got %0h want %0h", cyc, busy, e_busy); end
      total++; if (mem_we !== e_we) begin bad++; $display("FAIL rnd_we @%0d: got %0h want %0h", cyc, mem_we, e_we); end
      total++; if (d_gnt !== e_gnt) begin bad++; $display("FAIL rnd_dgnt @%0d: got %0h want %0h", cyc, d_gnt, e_gnt); end
      total++; if (p_stall !== e_pstall) begin bad++; $display("FAIL rnd_pstall @%0d: got %0h want %0h", cyc, p_stall, e_pstall); end
      total++; if ({p_rvalid, d_rvalid} !== {e_prv, e_drv}) begin bad++; $display("FAIL rnd_rvalid @%0d: got %0b want %0b", cyc, {p_rvalid, d_rvalid}, {e_prv, e_drv}); end
      total++; if (p_rdata !== exp_p_rdata || d_rdata !== exp_d_rdata) begin bad++; $display("FAIL rnd_rdata @%0d: got %0h/%0h want %0h/%0h", cyc, p_rdata, d_rdata, exp_p_rdata, exp_d_rdata); end
      if (e_addr_valid) begin
        total++; if (mem_addr !== e_addr) begin bad++; $display("FAIL rnd_addr @%0d: got %0h want %0h", cyc, mem_addr, e_addr); end
      end
      if (e_we == 4'hF) begin
        total++; if (mem_wdata !== e_wdata) begin bad++; $display("FAIL rnd_wdata @%0d: got %0h want %0h", cyc, mem_wdata, e_wdata); end
      end

      n_preq = p_req; n_pwe = p_we; n_paddr = p_addr; n_pwdata = p_wdata;
      n_dreq = d_req; n_dwe = d_we; n_daddr = d_addr; n_dwdata = d_wdata;
      if (!p_req || !e_pstall) begin
        n_preq = ($urandom_range(0, 99) < 60);
        n_pwe = $urandom_range(0, 1) == 1;
        n_paddr = rand_addr(); n_pwdata = $urandom;
      end
      if (!d_req || (d_we && e_gnt) || (!d_we && e_drv)) begin
        n_dreq = ($urandom_range(0, 99) < 40);
        n_dwe = $urandom_range(0, 1) == 1;
        n_daddr = rand_addr(); n_dwdata = $urandom;
      end

      @(posedge clk);
      model_advance();
      #1;
      p_req = n_preq; p_we = n_pwe; p_addr = n_paddr; p_wdata = n_pwdata;
      d_req = n_dreq; d_we = n_dwe; d_addr = n_daddr; d_wdata = n_dwdata;
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 0;
    drive_idle();
    x_p_req = 0; x_p_we = 0; x_p_addr = '0; x_p_wdata = '0;
    x_d_req = 0; x_d_we = 0; x_d_addr = '0; x_d_wdata = '0;
    step(); step();
    test_reset();
    test_p_write();
    test_p_read();
    test_contention();
    test_back_to_back_queued();
    test_reset_mid_read();
    test_lat3();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
